// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_pkg
//  Description : Shared types for the pipeline memory arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    typedef enum logic {
        OWNER_IF = 1'b0,
        OWNER_D  = 1'b1
    } arb_owner_e;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/riscv_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_mem_arbiter
//  Description : Fetch/data arbiter for a single-port fixed-latency memory,
//                with bounded fetch starvation and flush-killed fetch replies.
//  Revision    : 1.0 - initial release
// ============================================================================
module riscv_mem_arbiter
    import riscv_pkg::*;
#(
    parameter int WORD_SIZE   = 32,
    parameter int MEM_LATENCY = 1,
    parameter int MAX_D_BURST = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   if_req_i,
    input  logic [WORD_SIZE-1:0]   if_addr_i,
    output logic                   if_gnt_o,
    output logic                   if_rvalid_o,
    output logic [WORD_SIZE-1:0]   if_rdata_o,
    input  logic                   d_req_i,
    input  logic                   d_we_i,
    input  logic [WORD_SIZE/8-1:0] d_be_i,
    input  logic [WORD_SIZE-1:0]   d_addr_i,
    input  logic [WORD_SIZE-1:0]   d_wdata_i,
    output logic                   d_gnt_o,
    output logic                   d_rvalid_o,
    output logic [WORD_SIZE-1:0]   d_rdata_o,
    input  logic                   flush_i,
    output logic                   mem_req_o,
    output logic                   mem_we_o,
    output logic [WORD_SIZE/8-1:0] mem_be_o,
    output logic [WORD_SIZE-1:0]   mem_addr_o,
    output logic [WORD_SIZE-1:0]   mem_wdata_o,
    input  logic [WORD_SIZE-1:0]   mem_rdata_i
);

    localparam int LAT_W   = $clog2(MEM_LATENCY + 1);
    localparam int BURST_W = $clog2(MAX_D_BURST + 1);
    localparam logic [LAT_W-1:0]   C_LAT_MAX   = LAT_W'(MEM_LATENCY);
    localparam logic [BURST_W-1:0] C_BURST_MAX = BURST_W'(MAX_D_BURST);

    arb_state_e         r_state,   w_state_nxt;
    arb_owner_e         r_owner,   w_owner_nxt;
    logic               r_we,      w_we_nxt;
    logic               r_kill,    w_kill_nxt;
    logic [LAT_W-1:0]   r_lat_cnt, w_lat_cnt_nxt;
    logic [BURST_W-1:0] r_d_cnt,   w_d_cnt_nxt;

    logic w_resp, w_can_grant, w_if_ok, w_if_pri, w_d_win, w_if_win;

    // Grants are gated by rst_ni so every output reads 0 while reset is held.
    assign w_resp      = (r_state == ARB_BUSY) && (r_lat_cnt == C_LAT_MAX);
    assign w_can_grant = rst_ni && ((r_state == ARB_IDLE) || w_resp);
    assign w_if_ok     = if_req_i && !flush_i;
    assign w_if_pri    = if_req_i && (r_d_cnt == C_BURST_MAX);
    assign w_d_win     = w_can_grant && d_req_i && !(w_if_pri && w_if_ok);
    assign w_if_win    = w_can_grant && w_if_ok && !w_d_win;

    assign if_gnt_o    = w_if_win;
    assign d_gnt_o     = w_d_win;
    assign mem_req_o   = w_d_win || w_if_win;
    assign mem_we_o    = w_d_win && d_we_i;
    assign mem_be_o    = w_d_win ? d_be_i    : (w_if_win ? '1 : '0);
    assign mem_addr_o  = w_d_win ? d_addr_i  : (w_if_win ? if_addr_i : '0);
    assign mem_wdata_o = w_d_win ? d_wdata_i : '0;

    assign if_rvalid_o = w_resp && (r_owner == OWNER_IF) && !r_kill && !flush_i;
    assign d_rvalid_o  = w_resp && (r_owner == OWNER_D);
    assign if_rdata_o  = if_rvalid_o ? mem_rdata_i : '0;
    assign d_rdata_o   = (d_rvalid_o && !r_we) ? mem_rdata_i : '0;

    always_comb begin
        w_state_nxt   = r_state;
        w_owner_nxt   = r_owner;
        w_we_nxt      = r_we;
        w_kill_nxt    = r_kill;
        w_lat_cnt_nxt = r_lat_cnt;
        w_d_cnt_nxt   = r_d_cnt;

        if (w_d_win || w_if_win) begin
            w_state_nxt   = ARB_BUSY;
            w_owner_nxt   = w_d_win ? OWNER_D : OWNER_IF;
            w_we_nxt      = w_d_win && d_we_i;
            w_kill_nxt    = 1'b0;
            w_lat_cnt_nxt = LAT_W'(1);
        end else if (w_resp) begin
            w_state_nxt = ARB_IDLE;
            w_kill_nxt  = 1'b0;
        end else if (r_state == ARB_BUSY) begin
            w_lat_cnt_nxt = r_lat_cnt + LAT_W'(1);
            if ((r_owner == OWNER_IF) && flush_i) begin
                w_kill_nxt = 1'b1;
            end
        end

        // Burst counter only tracks data grants taken while a fetch waits.
        if (!if_req_i || w_if_win) begin
            w_d_cnt_nxt = '0;
        end else if (w_d_win && (r_d_cnt != C_BURST_MAX)) begin
            w_d_cnt_nxt = r_d_cnt + BURST_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= ARB_IDLE;
            r_owner   <= OWNER_IF;
            r_we      <= 1'b0;
            r_kill    <= 1'b0;
            r_lat_cnt <= '0;
            r_d_cnt   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_owner   <= w_owner_nxt;
            r_we      <= w_we_nxt;
            r_kill    <= w_kill_nxt;
            r_lat_cnt <= w_lat_cnt_nxt;
            r_d_cnt   <= w_d_cnt_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_riscv_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_riscv_mem_arbiter
//  Description : Directed bench: one arbiter with latency 1, one with latency 3.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_riscv_mem_arbiter;

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    // Instance A: MEM_LATENCY = 1
    logic        a_rst_n, a_if_req, a_if_gnt, a_if_rvalid, a_d_req, a_d_we, a_d_gnt, a_d_rvalid;
    logic        a_flush, a_mem_req, a_mem_we;
    logic [3:0]  a_d_be, a_mem_be;
    logic [31:0] a_if_addr, a_if_rdata, a_d_addr, a_d_wdata, a_d_rdata;
    logic [31:0] a_mem_addr, a_mem_wdata, a_mem_rdata;

    // Instance B: MEM_LATENCY = 3
    logic        b_rst_n, b_if_req, b_if_gnt, b_if_rvalid, b_d_req, b_d_we, b_d_gnt, b_d_rvalid;
    logic        b_flush, b_mem_req, b_mem_we;
    logic [3:0]  b_d_be, b_mem_be;
    logic [31:0] b_if_addr, b_if_rdata, b_d_addr, b_d_wdata, b_d_rdata;
    logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;

    riscv_mem_arbiter #(.WORD_SIZE(32), .MEM_LATENCY(1), .MAX_D_BURST(4)) dut_a (
        .clk_i(clk_i), .rst_ni(a_rst_n),
        .if_req_i(a_if_req), .if_addr_i(a_if_addr), .if_gnt_o(a_if_gnt),
        .if_rvalid_o(a_if_rvalid), .if_rdata_o(a_if_rdata),
        .d_req_i(a_d_req), .d_we_i(a_d_we), .d_be_i(a_d_be), .d_addr_i(a_d_addr),
        .d_wdata_i(a_d_wdata), .d_gnt_o(a_d_gnt), .d_rvalid_o(a_d_rvalid), .d_rdata_o(a_d_rdata),
        .flush_i(a_flush), .mem_req_o(a_mem_req), .mem_we_o(a_mem_we), .mem_be_o(a_mem_be),
        .mem_addr_o(a_mem_addr), .mem_wdata_o(a_mem_wdata), .mem_rdata_i(a_mem_rdata)
    );

    riscv_mem_arbiter #(.WORD_SIZE(32), .MEM_LATENCY(3), .MAX_D_BURST(4)) dut_b (
        .clk_i(clk_i), .rst_ni(b_rst_n),
        .if_req_i(b_if_req), .if_addr_i(b_if_addr), .if_gnt_o(b_if_gnt),
        .if_rvalid_o(b_if_rvalid), .if_rdata_o(b_if_rdata),
        .d_req_i(b_d_req), .d_we_i(b_d_we), .d_be_i(b_d_be), .d_addr_i(b_d_addr),
        .d_wdata_i(b_d_wdata), .d_gnt_o(b_d_gnt), .d_rvalid_o(b_d_rvalid), .d_rdata_o(b_d_rdata),
        .flush_i(b_flush), .mem_req_o(b_mem_req), .mem_we_o(b_mem_we), .mem_be_o(b_mem_be),
        .mem_addr_o(b_mem_addr), .mem_wdata_o(b_mem_wdata), .mem_rdata_i(b_mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs sampled on the falling edge.
    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        @(negedge clk_i);
    endtask

    initial begin
        a_rst_n = 1'b0; b_rst_n = 1'b0;
        a_if_req = 1'b1; a_if_addr = 32'h0; a_d_req = 1'b0; a_d_we = 1'b0; a_d_be = 4'h0;
        a_d_addr = 32'h0; a_d_wdata = 32'h0; a_flush = 1'b0; a_mem_rdata = 32'h0;
        b_if_req = 1'b0; b_if_addr = 32'h0; b_d_req = 1'b0; b_d_we = 1'b0; b_d_be = 4'h0;
        b_d_addr = 32'h0; b_d_wdata = 32'h0; b_flush = 1'b0; b_mem_rdata = 32'h0;

        // Reset held with a fetch request pending: everything stays 0
        settle();
        chk("rst_if_gnt",    32'(a_if_gnt),    32'h0);
        chk("rst_mem_req",   32'(a_mem_req),   32'h0);
        chk("rst_mem_be",    32'(a_mem_be),    32'h0);
        chk("rst_if_rvalid", 32'(a_if_rvalid), 32'h0);
        chk("rst_d_gnt",     32'(a_d_gnt),     32'h0);
        settle();

        // First cycle after release: fetch of address 0
        next_cycle();
        a_rst_n = 1'b1; b_rst_n = 1'b1;
        settle();
        chk("c0_if_gnt",   32'(a_if_gnt),   32'h1);
        chk("c0_mem_addr", a_mem_addr,      32'h0);
        chk("c0_mem_we",   32'(a_mem_we),   32'h0);
        chk("c0_mem_be",   32'(a_mem_be),   32'hF);

        next_cycle();
        a_if_req = 1'b0; a_mem_rdata = 32'h0000_0013;
        settle();
        chk("c1_if_rvalid", 32'(a_if_rvalid), 32'h1);
        chk("c1_if_rdata",  a_if_rdata,       32'h0000_0013);

        // Simultaneous fetch and load: data first, fetch next cycle
        next_cycle();
        a_if_req = 1'b1; a_if_addr = 32'h200; a_d_req = 1'b1; a_d_addr = 32'h100;
        settle();
        chk("c2_if_rvalid_gone", 32'(a_if_rvalid), 32'h0);
        chk("c2_d_gnt",    32'(a_d_gnt),  32'h1);
        chk("c2_if_gnt",   32'(a_if_gnt), 32'h0);
        chk("c2_mem_addr", a_mem_addr,    32'h100);

        next_cycle();
        a_d_req = 1'b0; a_mem_rdata = 32'hCAFE_0001;
        settle();
        chk("c3_if_gnt",    32'(a_if_gnt),    32'h1);
        chk("c3_mem_addr",  a_mem_addr,       32'h200);
        chk("c3_d_rvalid",  32'(a_d_rvalid),  32'h1);
        chk("c3_d_rdata",   a_d_rdata,        32'hCAFE_0001);
        chk("c3_if_rvalid", 32'(a_if_rvalid), 32'h0);
        chk("c3_if_rdata",  a_if_rdata,       32'h0);

        // Continuous traffic on both ports: D,D,D,D,IF,D,D,D,D,IF
        for (int i = 0; i < 10; i++) begin
            next_cycle();
            a_if_req = 1'b1; a_d_req = 1'b1; a_d_addr = 32'h180;
            settle();
            chk($sformatf("burst_%0d", i), 32'({a_if_gnt, a_d_gnt}),
                (i == 4 || i == 9) ? 32'h2 : 32'h1);
        end

        // Partial store
        next_cycle();
        a_if_req = 1'b0; a_d_req = 1'b1; a_d_we = 1'b1; a_d_be = 4'b0011;
        a_d_addr = 32'h40; a_d_wdata = 32'hDEAD_BEEF;
        settle();
        chk("st_d_gnt",     32'(a_d_gnt),  32'h1);
        chk("st_mem_we",    32'(a_mem_we), 32'h1);
        chk("st_mem_be",    32'(a_mem_be), 32'h3);
        chk("st_mem_addr",  a_mem_addr,    32'h40);
        chk("st_mem_wdata", a_mem_wdata,   32'hDEAD_BEEF);

        next_cycle();
        a_d_req = 1'b0; a_d_we = 1'b0; a_mem_rdata = 32'hFFFF_FFFF;
        settle();
        chk("st_d_rvalid",  32'(a_d_rvalid),  32'h1);
        chk("st_d_rdata",   a_d_rdata,        32'h0);
        chk("st_if_rvalid", 32'(a_if_rvalid), 32'h0);

        // Flush blocks a fetch grant but not a data grant
        next_cycle();
        a_if_req = 1'b1; a_flush = 1'b1;
        settle();
        chk("fl_if_gnt",  32'(a_if_gnt),  32'h0);
        chk("fl_mem_req", 32'(a_mem_req), 32'h0);
        next_cycle();
        a_d_req = 1'b1; a_d_addr = 32'h44;
        settle();
        chk("fl_d_gnt",   32'(a_d_gnt),  32'h1);
        chk("fl_if_gnt2", 32'(a_if_gnt), 32'h0);
        next_cycle();
        a_if_req = 1'b0; a_d_req = 1'b0; a_flush = 1'b0;

        // Latency 3: flushed fetch is killed, response cycle still grants
        next_cycle();
        b_if_req = 1'b1; b_if_addr = 32'h300;
        settle();
        chk("b_t0_if_gnt",   32'(b_if_gnt), 32'h1);
        chk("b_t0_mem_addr", b_mem_addr,    32'h300);
        next_cycle();
        b_if_req = 1'b0; b_flush = 1'b1;
        settle();
        chk("b_t1_mem_req", 32'(b_mem_req), 32'h0);
        next_cycle();
        b_flush = 1'b0;
        next_cycle();
        b_if_req = 1'b1; b_if_addr = 32'h304; b_mem_rdata = 32'h0000_1234;
        settle();
        chk("b_t3_if_rvalid", 32'(b_if_rvalid), 32'h0);
        chk("b_t3_if_gnt",    32'(b_if_gnt),    32'h1);
        chk("b_t3_mem_addr",  b_mem_addr,       32'h304);
        next_cycle();
        b_if_req = 1'b0;
        next_cycle();
        next_cycle();
        settle();
        chk("b_t6_if_rvalid", 32'(b_if_rvalid), 32'h1);
        chk("b_t6_if_rdata",  b_if_rdata,       32'h0000_1234);

        // Reset in the middle of a latency-3 load
        next_cycle();
        b_if_req = 1'b1; b_d_req = 1'b1; b_d_addr = 32'h500;
        settle();
        chk("b_rs_d_gnt", 32'(b_d_gnt), 32'h1);
        next_cycle();
        b_rst_n = 1'b0; b_d_req = 1'b0;
        settle();
        chk("b_rs_d_rvalid1", 32'(b_d_rvalid), 32'h0);
        chk("b_rs_mem_req",   32'(b_mem_req),  32'h0);
        next_cycle();
        settle();
        chk("b_rs_d_rvalid2", 32'(b_d_rvalid), 32'h0);
        next_cycle();
        b_rst_n = 1'b1;
        settle();
        chk("b_rs_d_rvalid3", 32'(b_d_rvalid),      32'h0);
        chk("b_rs_state",     32'(dut_b.r_state),   32'(riscv_pkg::ARB_IDLE));
        chk("b_rs_d_cnt",     32'(dut_b.r_d_cnt),   32'h0);
        chk("b_rs_if_gnt",    32'(b_if_gnt),        32'h1);
        next_cycle();
        b_if_req = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
